// File: rtl/forth_mem_arb.sv
// rtl/forth_mem_arb.sv - one-port RAM arbiter for forth fetch (I), data (D) and host (H) ports
// Build macro FORTH_ARB_RR_EN swaps fixed D>I>H priority for round-robin; host starvation override applies in both.
module forth_mem_arb #(
    parameter int            AW            = 10,
    parameter logic [AW-1:0] DATA_BASE     = 10'h300,
    parameter int            HOST_MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [15:0]   i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [7:0]    d_addr,
    input  logic [15:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [15:0]   d_rdata,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [15:0]   h_wdata,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [15:0]   h_rdata,
    output logic          cpu_stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata
);
    typedef enum logic [1:0] {IDLE, RD_I, RD_D, RD_H} owner_e;
    localparam logic [7:0] MAX_WAIT = 8'(HOST_MAX_WAIT);

    owner_e        owner_q, owner_d;
    logic [7:0]    wait_q, wait_d;
    logic          starve;
    logic          win_i, win_d, win_h;
    logic [AW-1:0] d_mapped;

    assign starve   = (wait_q == MAX_WAIT);
    assign d_mapped = DATA_BASE + AW'(d_addr);

`ifdef FORTH_ARB_RR_EN
    typedef enum logic [1:0] {LAST_D, LAST_I, LAST_H} last_e;
    last_e last_q, last_d;

    // Search begins at the requester after the previous winner.
    always_comb begin
        win_i = 1'b0;
        win_d = 1'b0;
        win_h = 1'b0;
        if (starve && h_req) begin
            win_h = 1'b1;
        end else begin
            case (last_q)
                LAST_D: begin
                    if (i_req)      win_i = 1'b1;
                    else if (h_req) win_h = 1'b1;
                    else if (d_req) win_d = 1'b1;
                end
                LAST_I: begin
                    if (h_req)      win_h = 1'b1;
                    else if (d_req) win_d = 1'b1;
                    else if (i_req) win_i = 1'b1;
                end
                default: begin
                    if (d_req)      win_d = 1'b1;
                    else if (i_req) win_i = 1'b1;
                    else if (h_req) win_h = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        last_d = last_q;
        if (d_gnt)      last_d = LAST_D;
        else if (i_gnt) last_d = LAST_I;
        else if (h_gnt) last_d = LAST_H;
    end
`else
    always_comb begin
        win_i = 1'b0;
        win_d = 1'b0;
        win_h = 1'b0;
        if (starve && h_req) win_h = 1'b1;
        else if (d_req)      win_d = 1'b1;
        else if (i_req)      win_i = 1'b1;
        else if (h_req)      win_h = 1'b1;
    end
`endif

    // Grants are forced low while reset is held so the RAM sees no access.
    assign i_gnt = reset & win_i;
    assign d_gnt = reset & win_d;
    assign h_gnt = reset & win_h;

    assign cpu_stall = (i_req & ~i_gnt) | (d_req & ~d_gnt);
    assign mem_en    = i_gnt | d_gnt | h_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_mapped;
            mem_wdata = d_wdata;
        end else if (i_gnt) begin
            mem_addr  = i_addr;
        end else if (h_gnt) begin
            mem_we    = h_we;
            mem_addr  = h_addr;
            mem_wdata = h_wdata;
        end
    end

    always_comb begin
        owner_d = IDLE;
        if (d_gnt && !d_we)      owner_d = RD_D;
        else if (i_gnt)          owner_d = RD_I;
        else if (h_gnt && !h_we) owner_d = RD_H;
    end

    always_comb begin
        wait_d = wait_q;
        if (h_gnt || !h_req) wait_d = '0;
        else if (!starve)    wait_d = wait_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= IDLE;
            wait_q  <= '0;
`ifdef FORTH_ARB_RR_EN
            last_q  <= LAST_H;
`endif
        end else begin
            owner_q <= owner_d;
            wait_q  <= wait_d;
`ifdef FORTH_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    // The owner tag steers the one-cycle-late RAM data to the requester that issued the read.
    assign i_rvalid = (owner_q == RD_I);
    assign d_rvalid = (owner_q == RD_D);
    assign h_rvalid = (owner_q == RD_H);
    assign i_rdata  = i_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;
    assign h_rdata  = h_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_forth_mem_arb.sv
// tb/tb_forth_mem_arb.sv - self-checking bench for forth_mem_arb against a queue-free behavioural arbiter model
// Honours FORTH_ARB_RR_EN the same way as the design.
module tb_forth_mem_arb;
    localparam int MAXW  = 8;
    localparam int DBASE = 'h300;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        i_req, d_req, d_we, h_req, h_we;
    logic [9:0]  i_addr, h_addr;
    logic [7:0]  d_addr;
    logic [15:0] d_wdata, h_wdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, h_gnt, h_rvalid;
    logic [15:0] i_rdata, d_rdata, h_rdata;
    logic        cpu_stall, mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    logic        w_d_req;
    logic [7:0]  w_d_addr;
    logic        w_i_gnt, w_i_rvalid, w_d_gnt, w_d_rvalid, w_h_gnt, w_h_rvalid;
    logic [15:0] w_i_rdata, w_d_rdata, w_h_rdata, w_mem_wdata;
    logic        w_cpu_stall, w_mem_en, w_mem_we;
    logic [9:0]  w_mem_addr;

    forth_mem_arb dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .cpu_stall(cpu_stall), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    forth_mem_arb #(.DATA_BASE(10'h3FF)) u_wrap (
        .clk(clk), .reset(reset),
        .i_req(1'b0), .i_addr(10'h000), .i_gnt(w_i_gnt), .i_rvalid(w_i_rvalid), .i_rdata(w_i_rdata),
        .d_req(w_d_req), .d_we(1'b0), .d_addr(w_d_addr), .d_wdata(16'h0000),
        .d_gnt(w_d_gnt), .d_rvalid(w_d_rvalid), .d_rdata(w_d_rdata),
        .h_req(1'b0), .h_we(1'b0), .h_addr(10'h000), .h_wdata(16'h0000),
        .h_gnt(w_h_gnt), .h_rvalid(w_h_rvalid), .h_rdata(w_h_rdata),
        .cpu_stall(w_cpu_stall), .mem_en(w_mem_en), .mem_we(w_mem_we),
        .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_rdata(16'h0000)
    );

    // Behavioural single-port RAM with one-cycle read latency.
    logic [15:0] ram [0:1023];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: requester codes 0 none, 1 D, 2 I, 3 H; m_last is round-robin position 0 D, 1 I, 2 H.
    bit          mdl_on = 1'b0;
    int          m_wait, m_pend, m_last;
    logic [15:0] m_pdata;
    logic [15:0] shadow [0:1023];

    function automatic int winner();
        bit r [3];
        r[0] = d_req; r[1] = i_req; r[2] = h_req;
        if (h_req && m_wait == MAXW) return 3;
`ifdef FORTH_ARB_RR_EN
        for (int k = 1; k <= 3; k++) begin
            int j;
            j = (m_last + k) % 3;
            if (r[j]) return j + 1;
        end
`else
        for (int j = 0; j < 3; j++) if (r[j]) return j + 1;
`endif
        return 0;
    endfunction

    always @(negedge clk) begin : model
        int          w;
        logic [9:0]  ea;
        logic        ewe;
        logic [15:0] ewd;
        if (mdl_on) begin
            if (!reset) begin
                chk("rst_gnt", {i_gnt, d_gnt, h_gnt}, 0);
                chk("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
                chk("rst_rvalid", {i_rvalid, d_rvalid, h_rvalid}, 0);
                chk("rst_rdata", {i_rdata | d_rdata | h_rdata}, 0);
                chk("rst_stall", cpu_stall, i_req | d_req);
                m_wait = 0; m_pend = 0; m_last = 2;
            end else begin
                w = winner();
                chk("d_gnt", d_gnt, w == 1);
                chk("i_gnt", i_gnt, w == 2);
                chk("h_gnt", h_gnt, w == 3);
                chk("cpu_stall", cpu_stall, (i_req && w != 2) || (d_req && w != 1));
                ea = '0; ewe = 1'b0; ewd = '0;
                if (w == 1) begin
                    ea = 10'((DBASE + int'(d_addr)) % 1024); ewe = d_we; ewd = d_wdata;
                end else if (w == 2) begin
                    ea = i_addr;
                end else if (w == 3) begin
                    ea = h_addr; ewe = h_we; ewd = h_wdata;
                end
                chk("mem_en", mem_en, w != 0);
                chk("mem_we", mem_we, ewe);
                chk("mem_addr", mem_addr, ea);
                chk("mem_wdata", mem_wdata, ewd);
                chk("d_rvalid", d_rvalid, m_pend == 1);
                chk("i_rvalid", i_rvalid, m_pend == 2);
                chk("h_rvalid", h_rvalid, m_pend == 3);
                chk("d_rdata", d_rdata, (m_pend == 1) ? m_pdata : 16'h0000);
                chk("i_rdata", i_rdata, (m_pend == 2) ? m_pdata : 16'h0000);
                chk("h_rdata", h_rdata, (m_pend == 3) ? m_pdata : 16'h0000);
                m_pend = 0;
                if (w != 0) begin
                    if (ewe) shadow[ea] = ewd;
                    else begin
                        m_pend  = w;
                        m_pdata = shadow[ea];
                    end
                    m_last = w - 1;
                end
                if (w == 3 || !h_req) m_wait = 0;
                else if (m_wait < MAXW) m_wait++;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        i_req = 1'b0; d_req = 1'b0; h_req = 1'b0; d_we = 1'b0; h_we = 1'b0;
    endtask

    initial begin : main
        int n;
        bit found, gi, gd, gh;
        int pi;
        int exp_seq [6];
        int code;
        for (int k = 0; k < 1024; k++) begin
            ram[k]    = 16'(k * 37 + 11);
            shadow[k] = 16'(k * 37 + 11);
        end
        ram[5] = 16'h1234; shadow[5] = 16'h1234;
        reset = 1'b0; drop_all();
        i_addr = '0; h_addr = '0; d_addr = '0; d_wdata = '0; h_wdata = '0;
        w_d_req = 1'b0; w_d_addr = '0;
        mdl_on = 1'b1;

        // Requests during reset must not be granted.
        d_req = 1'b1;
        @(negedge clk); chk("T0_rst_d_gnt", d_gnt, 0);
        chk("T0_rst_stall", cpu_stall, 1);
        nxt(); reset = 1'b1; d_req = 1'b0;

        // Fetch only.
        nxt(); i_req = 1'b1; i_addr = 10'h005;
        @(negedge clk);
        chk("T1_i_gnt", i_gnt, 1); chk("T1_mem_addr", mem_addr, 10'h005); chk("T1_stall", cpu_stall, 0);
        nxt(); i_req = 1'b0;
        @(negedge clk);
        chk("T1_i_rvalid", i_rvalid, 1); chk("T1_i_rdata", i_rdata, 16'h1234);

        // D write then read of the same word.
        nxt(); d_req = 1'b1; d_we = 1'b1; d_addr = 8'h56; d_wdata = 16'h2345;
        @(negedge clk);
        chk("T2_mem_we", mem_we, 1); chk("T2_mem_addr", mem_addr, 10'h356);
        nxt(); d_we = 1'b0;
        @(negedge clk);
        chk("T2_rd_gnt", d_gnt, 1); chk("T2_wr_no_rvalid", d_rvalid, 0);
        nxt(); d_req = 1'b0;
        @(negedge clk);
        chk("T2_d_rvalid", d_rvalid, 1); chk("T2_d_rdata", d_rdata, 16'h2345);

        // D address wraps modulo 2^AW.
        nxt(); w_d_req = 1'b1; w_d_addr = 8'hFF;
        @(negedge clk);
        chk("T6_wrap_gnt", w_d_gnt, 1); chk("T6_wrap_addr", w_mem_addr, 10'h0FE);
        nxt(); w_d_req = 1'b0;

        // Reset lands while an I read is in flight.
        i_req = 1'b1; i_addr = 10'h005;
        @(negedge clk); chk("T5_i_gnt", i_gnt, 1);
        nxt(); reset = 1'b0; i_req = 1'b0;
        @(negedge clk); chk("T5_rvalid_in_rst", i_rvalid, 0);
        nxt(); reset = 1'b1;
        @(negedge clk); chk("T5_rvalid_after", i_rvalid, 0);
        nxt(); i_req = 1'b1;
        @(negedge clk); chk("T5_regrant", i_gnt, 1);
        nxt(); i_req = 1'b0;
        @(negedge clk); chk("T5_rvalid", i_rvalid, 1); chk("T5_rdata", i_rdata, 16'h1234);
        nxt();

`ifdef FORTH_ARB_RR_EN
        reset = 1'b0; nxt(); reset = 1'b1;
        i_req = 1'b1; i_addr = 10'h010; d_req = 1'b1; d_addr = 8'h03; h_req = 1'b1; h_addr = 10'h020;
        exp_seq = '{1, 2, 3, 1, 2, 3};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            code = d_gnt ? 1 : (i_gnt ? 2 : (h_gnt ? 3 : 0));
            chk("T7_rr_order", code, exp_seq[k]);
            nxt();
        end
        drop_all(); nxt();
`else
        // Contention: D beats I and H, then I beats H.
        i_req = 1'b1; i_addr = 10'h010; d_req = 1'b1; d_addr = 8'h03; h_req = 1'b1; h_addr = 10'h020;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk("T3_d_wins", d_gnt, 1); chk("T3_h_loses", h_gnt, 0);
            nxt();
        end
        d_req = 1'b0;
        @(negedge clk); chk("T3_i_wins", i_gnt, 1); chk("T3_h_waits", h_gnt, 0);
        nxt(); drop_all(); nxt();

        // Starvation: H wins on its 9th waiting cycle, then its counter restarts.
        i_req = 1'b1; d_req = 1'b1; h_req = 1'b1;
        n = 0; found = 1'b0;
        for (int c = 1; c <= 20 && !found; c++) begin
            @(negedge clk);
            if (h_gnt) begin
                found = 1'b1; n = c;
            end else nxt();
        end
        chk("T4_starve_cycle", n, 9);
        nxt();
        @(negedge clk); chk("T4_wait_cleared", h_gnt, 0);
        nxt(); drop_all(); nxt();
`endif

        // Randomised traffic with occasional single-cycle resets.
        gi = 1'b0; gd = 1'b0; gh = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            pi = (cyc < 1500) ? 9 : 5;
            @(negedge clk); gi = i_gnt; gd = d_gnt; gh = h_gnt;
            nxt();
            reset = ($urandom_range(0, 199) != 0);
            if (!i_req || gi) begin
                i_req = ($urandom_range(0, 9) < pi); i_addr = 10'($urandom);
            end
            if (!d_req || gd) begin
                d_req = ($urandom_range(0, 9) < 6); d_we = $urandom_range(0, 1) == 1;
                d_addr = 8'($urandom); d_wdata = 16'($urandom);
            end
            if (!h_req || gh) begin
                h_req = ($urandom_range(0, 9) < 7); h_we = $urandom_range(0, 2) == 0;
                h_addr = 10'($urandom); h_wdata = 16'($urandom);
            end
        end
        nxt(); reset = 1'b1; drop_all();
        @(negedge clk);
        mdl_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
